// File: rtl/complex_dot_product_engine.sv
// Streaming complex dot-product engine: beats of NO_OF_UNITS elements are folded onto
// NO_OF_MULTS pipelined complex multipliers and summed into wrapping re/im accumulators.
module complex_dot_product_engine #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int NO_OF_UNITS   = 8,
  parameter int NO_OF_MULTS   = 4,
  parameter int ACC_WIDTH     = ELEMENT_WIDTH + 8,
  parameter int MULT_LAT      = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic                                 conj_mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_input,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_input,
  output logic [2*ACC_WIDTH-1:0]               dot_product_output,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 error,
  output logic [1:0]                           state_dbg
);

  localparam int H    = ELEMENT_WIDTH / 2;
  localparam int PW   = 2 * H + 1;
  localparam int FOLD = NO_OF_UNITS / NO_OF_MULTS;
  localparam int SW   = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int ULOG = $clog2(NO_OF_UNITS);
  localparam int BW   = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam logic [31:0] UMASK = 32'(NO_OF_UNITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            beats_left_q, beats_left_d;
  logic                   conj_q, conj_d;
  logic                   error_q, error_d;
  logic [BW-1:0]          a_beat_q, b_beat_q;
  logic                   seq_valid_q;
  logic [SW-1:0]          slice_q;
  logic [MULT_LAT-1:0]    pv_q;
  logic [ACC_WIDTH-1:0]   pre_q [MULT_LAT][NO_OF_MULTS];
  logic [ACC_WIDTH-1:0]   pim_q [MULT_LAT][NO_OF_MULTS];
  logic [ACC_WIDTH-1:0]   prod_re [NO_OF_MULTS];
  logic [ACC_WIDTH-1:0]   prod_im [NO_OF_MULTS];
  logic [ACC_WIDTH-1:0]   sum_re, sum_im;
  logic [ACC_WIDTH-1:0]   acc_re_q, acc_im_q;
  logic [2*ACC_WIDTH-1:0] dout_q;
  logic                   out_valid_q;
  logic                   accept, last_slice, pipe_empty;
  logic                   clr_acc, load_out, zero_out;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid && ready;
  // out_valid and dot_product_output stay frozen until that edge.
  assign last_slice = seq_valid_q && (slice_q == SW'(FOLD - 1));
  assign in_ready   = (state_q == LOAD) && (beats_left_q != '0) && (!seq_valid_q || last_slice);
  assign accept     = in_valid && in_ready;
  assign pipe_empty = !seq_valid_q && (pv_q == '0);

  assign dot_product_output = dout_q;
  assign out_valid          = out_valid_q;
  assign busy               = (state_q != IDLE);
  assign error              = error_q;
  assign state_dbg          = state_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    conj_d       = conj_q;
    error_d      = 1'b0;
    clr_acc      = 1'b0;
    load_out     = 1'b0;
    zero_out     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((total & UMASK) != '0) begin
            error_d = 1'b1;
          end else if (total == '0) begin
            zero_out = 1'b1;
            state_d  = DONE;
          end else begin
            clr_acc      = 1'b1;
            beats_left_d = total >> ULOG;
            conj_d       = conj_mode;
            state_d      = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) beats_left_d = beats_left_q - 32'd1;
        if (beats_left_q == '0 && (!seq_valid_q || last_slice)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) begin
          load_out = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      conj_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      conj_q       <= conj_d;
      error_q      <= error_d;
    end
  end

  // Slice sequencer: a new beat may replace the one issuing its last slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_beat_q    <= '0;
      b_beat_q    <= '0;
      seq_valid_q <= 1'b0;
      slice_q     <= '0;
    end else if (accept) begin
      a_beat_q    <= first_row_input;
      b_beat_q    <= second_row_input;
      seq_valid_q <= 1'b1;
      slice_q     <= '0;
    end else if (seq_valid_q) begin
      if (last_slice) seq_valid_q <= 1'b0;
      else            slice_q     <= slice_q + SW'(1);
    end
  end

  for (genvar m = 0; m < NO_OF_MULTS; m++) begin : g_lane
    logic [ELEMENT_WIDTH-1:0] ae, be;
    logic signed [H-1:0]      ar, ai, br, bi;
    logic signed [2*H-1:0]    rr, ii, ir, ri;
    logic signed [PW-1:0]     re_p, im_p;

    // Element 0 sits in the MSBs, so slice s starts at element s*NO_OF_MULTS from the top.
    assign ae = a_beat_q[BW-1-(int'(slice_q)*NO_OF_MULTS+m)*ELEMENT_WIDTH -: ELEMENT_WIDTH];
    assign be = b_beat_q[BW-1-(int'(slice_q)*NO_OF_MULTS+m)*ELEMENT_WIDTH -: ELEMENT_WIDTH];
    assign ar = ae[ELEMENT_WIDTH-1:H];
    assign ai = ae[H-1:0];
    assign br = be[ELEMENT_WIDTH-1:H];
    assign bi = be[H-1:0];
    assign rr = (2*H)'(ar) * (2*H)'(br);
    assign ii = (2*H)'(ai) * (2*H)'(bi);
    assign ir = (2*H)'(ai) * (2*H)'(br);
    assign ri = (2*H)'(ar) * (2*H)'(bi);
    assign re_p = conj_q ? (PW'(rr) + PW'(ii)) : (PW'(rr) - PW'(ii));
    assign im_p = conj_q ? (PW'(ir) - PW'(ri)) : (PW'(ri) + PW'(ir));
    assign prod_re[m] = ACC_WIDTH'(re_p);
    assign prod_im[m] = ACC_WIDTH'(im_p);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= seq_valid_q;
      for (int k = 1; k < MULT_LAT; k++) pv_q[k] <= pv_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pre_q[0] <= prod_re;
    pim_q[0] <= prod_im;
    for (int k = 1; k < MULT_LAT; k++) begin
      pre_q[k] <= pre_q[k-1];
      pim_q[k] <= pim_q[k-1];
    end
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int m = 0; m < NO_OF_MULTS; m++) begin
      sum_re = sum_re + pre_q[MULT_LAT-1][m];
      sum_im = sum_im + pim_q[MULT_LAT-1][m];
    end
  end

  // Accumulators wrap modulo 2^ACC_WIDTH by design.
  always_ff @(posedge clk) begin
    if (reset || clr_acc) begin
      acc_re_q <= '0;
      acc_im_q <= '0;
    end else if (pv_q[MULT_LAT-1]) begin
      acc_re_q <= acc_re_q + sum_re;
      acc_im_q <= acc_im_q + sum_im;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (zero_out) begin
      dout_q      <= '0;
      out_valid_q <= 1'b1;
    end else if (load_out) begin
      dout_q      <= {acc_re_q, acc_im_q};
      out_valid_q <= 1'b1;
    end else if (state_q == DONE && out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: doc/complex_dot_product_engine.md
Name: complex_dot_product_engine

Overview:
- Parametrised successor to the fixed 8-lane conjugate dot-product unit.
- Computes the complex dot product of two vectors of length `total` streamed in beats of NO_OF_UNITS elements, using NO_OF_MULTS time-shared complex multipliers and a wide accumulator.
- Adds a runtime conjugate/plain mode, valid/ready handshakes on both sides, an illegal-length error flag and deterministic fixed latency.
- Sits between the row/vector fetch logic and the solver datapath.

Parameters:
- ELEMENT_WIDTH, 64, complex element {re[H-1:0] in upper half, im in lower half}, H=ELEMENT_WIDTH/2, signed two's complement.
- NO_OF_UNITS, 8, elements per input beat; power of two, >=2.
- NO_OF_MULTS, 4, parallel complex multipliers; divides NO_OF_UNITS; FOLD = NO_OF_UNITS/NO_OF_MULTS.
- ACC_WIDTH, 2*H+8, width of each accumulator half (re and im).
- MULT_LAT, 2, registered multiplier pipeline depth (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch a job; sampled only in IDLE.
- total  in  32  vector length in elements; must be a multiple of NO_OF_UNITS.
- conj_mode  in  1  1: sum a*conj(b); 0: sum a*b. Latched at start.
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- first_row_input  in  ELEMENT_WIDTH*NO_OF_UNITS  vector a beat; element 0 in MSBs.
- second_row_input  in  ELEMENT_WIDTH*NO_OF_UNITS  vector b beat, same layout.
- dot_product_output  out  2*ACC_WIDTH  {re_acc, im_acc}.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- busy  out  1  state != IDLE.
- error  out  1  one-cycle pulse on an illegal total.

Behaviour:
- Reset values: in_ready=0, out_valid=0, busy=0, error=0, dot_product_output=0, accumulators=0, state=IDLE. Reset mid-job aborts immediately: counters cleared and in-flight products discarded.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start with total%NO_OF_UNITS!=0: error=1 for one cycle, stay IDLE.
  - start with total==0: go to DONE with result 0; out_valid asserted the next cycle.
  - Otherwise: clear accumulators, beats_left=total/NO_OF_UNITS, latch conj_mode, go to LOAD.
- LOAD:
  - in_ready=1 when beats_left>0 and the slice sequencer is empty or issuing its last slice. This gives back-to-back throughput of one beat per FOLD cycles.
  - An accepted beat is registered.
  - Over the next FOLD cycles, slice s (s=0..FOLD-1) feeds elements s*NO_OF_MULTS..s*NO_OF_MULTS+NO_OF_MULTS-1 to the multipliers, MSB slice first.
  - When beats_left reaches 0 and the last slice has issued, go to DRAIN.
- Arithmetic per element:
  - conj: re=ar*br+ai*bi, im=ai*br-ar*bi.
  - plain: re=ar*br-ai*bi, im=ar*bi+ai*br.
  - Products are full 2H+1 bits, sign-extended to ACC_WIDTH.
  - Lane sum is added to the accumulator one cycle after the product exits the multiplier.
  - Accumulator overflow wraps modulo 2^ACC_WIDTH; no saturation.
- DRAIN: wait for the pipeline to empty, copy accumulators to dot_product_output, set out_valid, go to DONE.
- Latency: out_valid rises exactly FOLD+MULT_LAT+1 cycles after the edge accepting the final beat.
- DONE:
  - out_valid and dot_product_output are held stable until out_valid&&out_ready, then go to IDLE.
  - start is ignored in every state except IDLE, including the DONE handoff cycle.
- in_valid gaps in LOAD simply stall; they add no error and no accumulation.
- total and conj_mode changes after start have no effect.

Test Plan:
- H=32, NO_OF_UNITS=8, NO_OF_MULTS=4, total=8, all a=1+2i, b=3+4i, conj_mode=1 -> dot_product_output re=88, im=16. Same with conj_mode=0 -> re=-40, im=80.
- total=32, four beats back-to-back with in_valid=1 -> in_ready pattern 1,0,1,0...; out_valid exactly 5 cycles after the 4th acceptance; result equals a software reference over random signed 32-bit data.
- total=12, start -> error pulses for 1 cycle; busy stays 0; in_ready stays 0.
- total=0, start -> out_valid the next cycle with output 0; busy=1 until out_ready.
- Result ready, out_ready=0 for 5 cycles with start=1 pulses -> output stable, no new job; out_ready=1 -> IDLE next cycle.
- reset asserted after 2 of 4 beats -> all outputs 0 next cycle; a new total=8 job then gives a clean, correct result.
